// File: rtl/mem_wb_elastic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_wb_elastic                                                           |
// | Elastic DEPTH-entry MEM->WB buffer with youngest-wins forwarding lookup. |
// | Optional macro MEM_WB_ELASTIC_BYPASS_EN: same-cycle bypass when empty.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_wb_elastic #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          alu_result_in,
  input  logic [XLEN-1:0]          load_data_in,
  input  logic [REG_AW-1:0]        rd_in,
  input  logic                     wb_reg_file_in,
  input  logic                     memtoreg_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          wb_data_out,
  output logic [REG_AW-1:0]        rd_out,
  output logic                     wb_reg_file_out,
  input  logic [REG_AW-1:0]        fwd_rs1_addr,
  input  logic [REG_AW-1:0]        fwd_rs2_addr,
  output logic                     fwd_rs1_hit,
  output logic                     fwd_rs2_hit,
  output logic [XLEN-1:0]          fwd_rs1_data,
  output logic [XLEN-1:0]          fwd_rs2_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [XLEN-1:0]   r_data [DEPTH];
  logic [REG_AW-1:0] r_rd   [DEPTH];
  logic              r_en   [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic [XLEN-1:0]   w_sel_data;
  logic              w_wb_en;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_stored;

  assign w_sel_data = memtoreg_in ? load_data_in : alu_result_in;
  // Writes to x0 are architecturally discarded, so never let them forward.
  assign w_wb_en    = wb_reg_file_in && (rd_in != '0);
  assign w_stored   = (r_count != '0);

`ifdef MEM_WB_ELASTIC_BYPASS_EN
  assign w_bypass = !w_stored && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready = (r_count != C_FULL);
  assign w_push   = in_valid && in_ready && !flush && !(w_bypass && out_ready);
  assign w_pop    = w_stored && out_ready && !flush;

  assign out_valid       = w_stored || w_bypass;
  assign wb_data_out     = w_bypass ? w_sel_data : r_data[r_rd_ptr];
  assign rd_out          = w_bypass ? rd_in : r_rd[r_rd_ptr];
  assign wb_reg_file_out = out_valid && (w_bypass ? w_wb_en : r_en[r_rd_ptr]);
  assign occupancy       = r_count;

  // Walk head -> tail so later (younger) matches overwrite older ones.
  function automatic logic [XLEN:0] fwd_lookup(input logic [REG_AW-1:0] addr);
    logic [XLEN:0] res;
    logic [PW-1:0] idx;
    res = '0;
    idx = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && r_en[idx] && (r_rd[idx] == addr) && (addr != '0))
        res = {1'b1, r_data[idx]};
      idx = idx + 1'b1;
    end
    if (w_bypass && w_wb_en && (rd_in == addr) && (addr != '0))
      res = {1'b1, w_sel_data};
    return res;
  endfunction

  assign {fwd_rs1_hit, fwd_rs1_data} = fwd_lookup(fwd_rs1_addr);
  assign {fwd_rs2_hit, fwd_rs2_data} = fwd_lookup(fwd_rs2_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_rd[i]   <= '0;
        r_en[i]   <= 1'b0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_en[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= w_sel_data;
        r_rd[r_wr_ptr]   <= rd_in;
        r_en[r_wr_ptr]   <= w_wb_en;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_elastic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_wb_elastic                                                        |
// | Directed and randomized checks of mem_wb_elastic against a queue model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_wb_elastic;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [XLEN-1:0]   alu_result_in = '0;
  logic [XLEN-1:0]   load_data_in = '0;
  logic [REG_AW-1:0] rd_in = '0;
  logic              wb_reg_file_in = 1'b0;
  logic              memtoreg_in = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   wb_data_out;
  logic [REG_AW-1:0] rd_out;
  logic              wb_reg_file_out;
  logic [REG_AW-1:0] fwd_rs1_addr = '0;
  logic [REG_AW-1:0] fwd_rs2_addr = '0;
  logic              fwd_rs1_hit;
  logic              fwd_rs2_hit;
  logic [XLEN-1:0]   fwd_rs1_data;
  logic [XLEN-1:0]   fwd_rs2_data;
  logic [CW-1:0]     occupancy;

  mem_wb_elastic #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_in(alu_result_in), .load_data_in(load_data_in),
    .rd_in(rd_in), .wb_reg_file_in(wb_reg_file_in), .memtoreg_in(memtoreg_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data_out(wb_data_out), .rd_out(rd_out), .wb_reg_file_out(wb_reg_file_out),
    .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [REG_AW-1:0] rd;
    logic              en;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t input_entry();
    ent_t e;
    e.data = memtoreg_in ? load_data_in : alu_result_in;
    e.rd   = rd_in;
    e.en   = wb_reg_file_in && (rd_in != 0);
    return e;
  endfunction

  // Compare every output against the queue model for the current inputs.
  task automatic check_outputs();
    ent_t cand[$];
    ent_t head;
    logic exp_valid;
    logic h1, h2;
    logic [XLEN-1:0] d1, d2;
    cand = q;
    exp_valid = (q.size() != 0);
    head = exp_valid ? q[0] : '0;
`ifdef MEM_WB_ELASTIC_BYPASS_EN
    if (q.size() == 0 && in_valid && !flush) begin
      exp_valid = 1'b1;
      head = input_entry();
      cand.push_back(head);
    end
`endif
    check_eq("out_valid", out_valid, exp_valid);
    check_eq("in_ready", in_ready, q.size() != DEPTH);
    check_eq("occupancy", occupancy, q.size());
    if (exp_valid) begin
      check_eq("wb_data_out", wb_data_out, head.data);
      check_eq("rd_out", rd_out, head.rd);
      check_eq("wb_reg_file_out", wb_reg_file_out, head.en);
    end else begin
      check_eq("wb_en_idle", wb_reg_file_out, 1'b0);
    end
    h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
    foreach (cand[i]) begin
      if (cand[i].en && fwd_rs1_addr != 0 && cand[i].rd == fwd_rs1_addr) begin
        h1 = 1'b1; d1 = cand[i].data;
      end
      if (cand[i].en && fwd_rs2_addr != 0 && cand[i].rd == fwd_rs2_addr) begin
        h2 = 1'b1; d2 = cand[i].data;
      end
    end
    check_eq("fwd_rs1_hit", fwd_rs1_hit, h1);
    check_eq("fwd_rs1_data", fwd_rs1_data, d1);
    check_eq("fwd_rs2_hit", fwd_rs2_hit, h2);
    check_eq("fwd_rs2_data", fwd_rs2_data, d2);
  endtask

  // One clock: drive at negedge, check, advance model at posedge, then idle inputs.
  task automatic step(input logic iv, input logic orr, input logic fl,
                      input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld,
                      input logic [REG_AW-1:0] rd, input logic we, input logic m2r,
                      input logic [REG_AW-1:0] a1, input logic [REG_AW-1:0] a2);
    ent_t e;
    logic push, pop;
    @(negedge clk);
    in_valid = iv; out_ready = orr; flush = fl;
    alu_result_in = alu; load_data_in = ld; rd_in = rd;
    wb_reg_file_in = we; memtoreg_in = m2r;
    fwd_rs1_addr = a1; fwd_rs2_addr = a2;
    #1;
    check_outputs();
    e    = input_entry();
    push = iv && !fl && (q.size() < DEPTH);
    pop  = (q.size() > 0) && orr && !fl;
`ifdef MEM_WB_ELASTIC_BYPASS_EN
    if (q.size() == 0 && orr) push = 1'b0;
`endif
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [REG_AW-1:0] pick_addr();
    if (q.size() != 0 && $urandom_range(0, 1) == 1)
      return q[$urandom_range(0, q.size() - 1)].rd;
    return REG_AW'($urandom_range(0, 7));
  endfunction

  initial begin
    // Reset state
    #2;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_wb_data", wb_data_out, 0);
    check_eq("rst_rd_out", rd_out, 0);
    check_eq("rst_occupancy", occupancy, 0);
    check_eq("rst_fwd_hit", {fwd_rs1_hit, fwd_rs2_hit}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Single entry, 1-cycle latency
    step(1, 1, 0, 32'h11, 32'h0, 5'd3, 1, 0, 5'd0, 5'd0);
    check_eq("single_valid", out_valid, 1'b1);
    check_eq("single_data", wb_data_out, 32'h11);
    check_eq("single_rd", rd_out, 5'd3);
    step(0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    check_eq("single_drained", out_valid, 1'b0);

    // Fill, refuse third, drain in order
    step(1, 0, 0, 32'hA1, 0, 5'd1, 1, 0, 5'd1, 5'd2);
    step(1, 0, 0, 32'hB2, 0, 5'd2, 1, 0, 5'd1, 5'd2);
    check_eq("full_occ", occupancy, 2);
    check_eq("full_in_ready", in_ready, 1'b0);
    step(1, 0, 0, 32'hC3, 0, 5'd4, 1, 0, 5'd4, 5'd2);
    step(0, 1, 0, 0, 0, 0, 0, 0, 5'd4, 5'd0);
    check_eq("drain_second", wb_data_out, 32'hB2);
    step(0, 1, 0, 0, 0, 0, 0, 0, 5'd4, 5'd0);
    check_eq("drain_empty", out_valid, 1'b0);

    // Youngest-wins forwarding, x0 never hits
    step(1, 0, 0, 32'hA, 0, 5'd5, 1, 0, 5'd5, 5'd0);
    step(1, 0, 0, 32'hB, 0, 5'd5, 1, 0, 5'd5, 5'd0);
    check_eq("fwd_young_hit", fwd_rs1_hit, 1'b1);
    check_eq("fwd_young_data", fwd_rs1_data, 32'hB);
    check_eq("fwd_x0_hit", fwd_rs2_hit, 1'b0);

    // Flush with a same-cycle push
    step(1, 0, 1, 32'hDD, 0, 5'd5, 1, 0, 5'd5, 5'd5);
    check_eq("flush_occ", occupancy, 0);
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_fwd", {fwd_rs1_hit, fwd_rs2_hit}, 2'b00);

    // Load data selection; write to x0 stored with wb_en=0
    step(1, 0, 0, 32'hBEEF, 32'hDEAD, 5'd7, 1, 1, 5'd7, 5'd0);
    check_eq("load_sel", wb_data_out, 32'hDEAD);
    step(1, 1, 0, 32'h5, 0, 5'd0, 1, 0, 5'd0, 5'd0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    check_eq("x0_wb_en", wb_reg_file_out, 1'b0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);

    // Streaming across pointer wrap at occupancy 1
    step(1, 1, 0, 32'h100, 0, 5'd9, 1, 0, 5'd9, 5'd0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 32'h200 + i, 0, REG_AW'(i + 10), 1, 0, REG_AW'(i + 9), 5'd9);
      check_eq("stream_occ", occupancy, 1);
    end

    // Asynchronous reset mid-stream
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; fwd_rs1_addr = 5'd19;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 1'b0);
    check_eq("arst_occ", occupancy, 0);
    check_eq("arst_data", wb_data_out, 0);
    check_eq("arst_rd", rd_out, 0);
    check_eq("arst_fwd", fwd_rs1_hit, 1'b0);
    q.delete();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom, $urandom, REG_AW'($urandom_range(0, 7)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
           pick_addr(), pick_addr());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
